// File: rtl/issue_fifo.sv
// -----------------------------------------------------------------------------
// issue_fifo
//   N-entry issue queue between dispatch (push at tail) and register read
//   (pop from head). First-word fall-through: the head entry is always
//   presented on dout while valid is high. A flush on redirect discards every
//   entry. When full, a push is still accepted if a pop is accepted in the
//   same cycle.
//
// Parameters
//   WIDTH      bits per entry
//   DEPTH      number of entries (>= 2, any value; pointers wrap explicitly)
//   AF_THRESH  almost_full asserts when free slots <= AF_THRESH (0..DEPTH-1)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   flush        discard all entries; highest priority
//   push / din   enqueue din at the tail
//   push_ok      push accepted this cycle
//   pop          consume the head entry
//   dout         head entry, '0 whenever valid is low
//   valid        dout holds a real entry
//   empty/full   occupancy == 0 / occupancy == DEPTH
//   almost_full  DEPTH - occupancy <= AF_THRESH
//   count        current occupancy
//
// Valid/ready: a push transfers in a cycle where push && push_ok; a pop
// transfers in a cycle where pop && valid && !flush. Both are evaluated
// combinationally and take effect at the next rising edge.
//
// Configuration
//   ISSUE_FIFO_BYPASS_EN  when defined, an empty queue forwards din to dout
//                         in the same cycle as the push; a simultaneous pop
//                         consumes it without it ever being stored.
// -----------------------------------------------------------------------------
module issue_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   output logic                         push_ok,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         valid,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH-1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   // free <= AF_THRESH  <=>  count >= DEPTH - AF_THRESH (always >= 1)
   localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH-AF_THRESH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic w_empty;
   logic w_full;
   logic w_bypass;
   logic w_consume;
   logic w_pop_acc;
   logic w_push_acc;
   logic w_write;
   logic w_head_adv;
   logic [PW-1:0] w_head_nxt;
   logic [PW-1:0] w_tail_nxt;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

`ifdef ISSUE_FIFO_BYPASS_EN
   // Empty queue forwards the incoming entry straight to the head.
   assign w_bypass = rst & w_empty & push & ~flush;
`else
   assign w_bypass = 1'b0;
`endif

   // Acceptance is gated by rst so nothing is reported accepted while the
   // queue is held in reset.
   assign w_pop_acc  = rst & pop & ~flush & (~w_empty | w_bypass);
   assign w_push_acc = rst & push & ~flush & (~w_full | w_pop_acc);
   assign push_ok    = w_push_acc;

   // Bypassed entry popped in the same cycle: never stored, pointers stay.
   assign w_consume  = w_bypass & pop;
   assign w_write    = w_push_acc & ~w_consume;
   assign w_head_adv = w_pop_acc & ~w_consume;

   assign w_head_nxt = (r_head == LAST_IDX) ? '0 : r_head + 1'b1;
   assign w_tail_nxt = (r_tail == LAST_IDX) ? '0 : r_tail + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_write)    r_tail <= w_tail_nxt;
         if (w_head_adv) r_head <= w_head_nxt;
         r_count <= r_count + CW'(w_push_acc) - CW'(w_pop_acc);
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_write) r_mem[r_tail] <= din;
   end

   always_comb begin
      dout = '0;
      if (w_bypass)      dout = din;
      else if (!w_empty) dout = r_mem[r_head];
   end

   // Status comes from the registered count only.
   assign valid       = ~w_empty | w_bypass;
   assign empty       = w_empty;
   assign full        = w_full;
   assign almost_full = (r_count >= AF_CNT);
   assign count       = r_count;

endmodule

// File: tb/tb_issue_fifo.sv
module tb_issue_fifo;

   localparam int W = 32;
`ifdef ISSUE_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance a: DEPTH=8, AF_THRESH=2
   logic         a_rst = 1'b1, a_flush = 1'b0, a_push = 1'b0, a_pop = 1'b0;
   logic [W-1:0] a_din = '0;
   logic         a_push_ok, a_valid, a_empty, a_full, a_af;
   logic [W-1:0] a_dout;
   logic [3:0]   a_count;

   // instance b: DEPTH=5, AF_THRESH=2
   logic         b_rst = 1'b1, b_flush = 1'b0, b_push = 1'b0, b_pop = 1'b0;
   logic [W-1:0] b_din = '0;
   logic         b_push_ok, b_valid, b_empty, b_full, b_af;
   logic [W-1:0] b_dout;
   logic [2:0]   b_count;

   issue_fifo #(.WIDTH(W), .DEPTH(8), .AF_THRESH(2)) u_a (
      .clk(clk), .rst(a_rst), .flush(a_flush), .push(a_push), .din(a_din),
      .push_ok(a_push_ok), .pop(a_pop), .dout(a_dout), .valid(a_valid),
      .empty(a_empty), .full(a_full), .almost_full(a_af), .count(a_count));

   issue_fifo #(.WIDTH(W), .DEPTH(5), .AF_THRESH(2)) u_b (
      .clk(clk), .rst(b_rst), .flush(b_flush), .push(b_push), .din(b_din),
      .push_ok(b_push_ok), .pop(b_pop), .dout(b_dout), .valid(b_valid),
      .empty(b_empty), .full(b_full), .almost_full(b_af), .count(b_count));

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      a_push = 1'b1; a_din = 32'hDEAD;
      a_rst = 1'b0; b_rst = 1'b0;
      #1;
      total++; if (a_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
      total++; if (a_empty !== 1'b1 || a_full !== 1'b0 || a_af !== 1'b0) begin bad++; $display("FAIL reset_flags got e=%b f=%b af=%b exp e=1 f=0 af=0", a_empty, a_full, a_af); end
      total++; if (a_valid !== 1'b0 || a_push_ok !== 1'b0 || a_dout !== '0) begin bad++; $display("FAIL reset_out got v=%b ok=%b d=%h exp 0 0 0", a_valid, a_push_ok, a_dout); end
      tick(); tick();
      a_push = 1'b0;
      a_rst = 1'b1; b_rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         a_push = 1'b1; a_din = W'(32'h11 + i);
         #1;
         total++; if (a_push_ok !== 1'b1) begin bad++; $display("FAIL fill_push_ok i=%0d got=%b exp=1", i, a_push_ok); end
         if (i > 0) begin
            total++; if (a_dout !== 32'h11) begin bad++; $display("FAIL fill_dout i=%0d got=%h exp=11", i, a_dout); end
         end
         exp_q.push_back(a_din);
         tick();
         a_push = 1'b0;
         #1;
         total++; if (a_count !== 4'(i+1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", a_count, i+1); end
         total++; if (a_af !== (i+1 >= 6)) begin bad++; $display("FAIL fill_af count=%0d got=%b exp=%b", i+1, a_af, (i+1 >= 6)); end
         total++; if (a_full !== (i+1 == 8)) begin bad++; $display("FAIL fill_full count=%0d got=%b exp=%b", i+1, a_full, (i+1 == 8)); end
      end
   endtask

   task automatic test_overflow();
      a_push = 1'b1; a_din = 32'h99; a_pop = 1'b0;
      #1;
      total++; if (a_push_ok !== 1'b0) begin bad++; $display("FAIL overflow_push_ok got=%b exp=0", a_push_ok); end
      tick();
      a_push = 1'b0;
      #1;
      total++; if (a_count !== 4'd8) begin bad++; $display("FAIL overflow_count got=%0d exp=8", a_count); end
   endtask

   task automatic test_full_push_pop();
      logic [W-1:0] e;
      a_push = 1'b1; a_din = 32'hAA; a_pop = 1'b1;
      #1;
      total++; if (a_push_ok !== 1'b1) begin bad++; $display("FAIL fpp_push_ok got=%b exp=1", a_push_ok); end
      total++; if (a_dout !== 32'h11) begin bad++; $display("FAIL fpp_head got=%h exp=11", a_dout); end
      void'(exp_q.pop_front());
      exp_q.push_back(32'hAA);
      tick();
      a_push = 1'b0; a_pop = 1'b0;
      #1;
      total++; if (a_count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", a_count); end
      total++; if (a_dout !== 32'h12) begin bad++; $display("FAIL fpp_next got=%h exp=12", a_dout); end
      // drain: expect 12..18 then AA; 99 must never show up
      for (int k = 0; k < 8; k++) begin
         a_pop = 1'b1;
         #1;
         e = exp_q.pop_front();
         total++; if (a_valid !== 1'b1 || a_dout !== e) begin bad++; $display("FAIL drain k=%0d got v=%b d=%h exp v=1 d=%h", k, a_valid, a_dout, e); end
         tick();
      end
      a_pop = 1'b0;
      #1;
      total++; if (a_empty !== 1'b1 || a_count !== 4'd0) begin bad++; $display("FAIL drain_empty got e=%b c=%0d exp e=1 c=0", a_empty, a_count); end
   endtask

   task automatic test_wrap();
      bit ok_cnt = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         b_push = 1'b1; b_din = W'(i);
         tick();
      end
      b_push = 1'b0;
      #1;
      total++; if (b_count !== 3'd2) begin bad++; $display("FAIL wrap_prefill got=%0d exp=2", b_count); end
      for (int i = 0; i < 13; i++) begin
         b_push = 1'b1; b_pop = 1'b1; b_din = W'(i + 3);
         #1;
         total++; if (b_dout !== W'(i + 1)) begin bad++; $display("FAIL wrap_out i=%0d got=%0d exp=%0d", i, b_dout, i + 1); end
         tick();
         if (b_count !== 3'd2) ok_cnt = 1'b0;
      end
      b_push = 1'b0; b_pop = 1'b0;
      #1;
      total++; if (ok_cnt !== 1'b1 || b_count !== 3'd2) begin bad++; $display("FAIL wrap_count got=%0d exp=2 steady=%b", b_count, ok_cnt); end
      total++; if (b_dout !== 32'd14) begin bad++; $display("FAIL wrap_head got=%0d exp=14", b_dout); end
      b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      #1;
      total++; if (b_empty !== 1'b1) begin bad++; $display("FAIL wrap_flush got e=%b exp=1", b_empty); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         a_push = 1'b1; a_din = $urandom;
         tick();
      end
      a_push = 1'b0;
      #1;
      total++; if (a_count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", a_count); end
      a_flush = 1'b1; a_push = 1'b1; a_din = 32'h77; a_pop = 1'b1;
      #1;
      total++; if (a_push_ok !== 1'b0) begin bad++; $display("FAIL flush_push_ok got=%b exp=0", a_push_ok); end
      tick();
      a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0;
      #1;
      total++; if (a_count !== 4'd0 || a_empty !== 1'b1 || a_valid !== 1'b0 || a_dout !== '0) begin bad++; $display("FAIL flush_after got c=%0d e=%b v=%b d=%h exp 0 1 0 0", a_count, a_empty, a_valid, a_dout); end
      a_push = 1'b1; a_din = 32'h21;
      tick();
      a_push = 1'b0;
      #1;
      total++; if (a_dout !== 32'h21 || a_count !== 4'd1) begin bad++; $display("FAIL flush_next got d=%h c=%0d exp d=21 c=1", a_dout, a_count); end
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      // reset in the middle of a burst, between clock edges
      for (int i = 0; i < 3; i++) begin
         a_push = 1'b1; a_din = W'(32'h40 + i);
         tick();
      end
      #2;
      a_rst = 1'b0;
      #1;
      total++; if (a_count !== 4'd0 || a_empty !== 1'b1 || a_valid !== 1'b0 || a_dout !== '0 || a_push_ok !== 1'b0) begin bad++; $display("FAIL async_rst got c=%0d e=%b v=%b d=%h ok=%b exp 0 1 0 0 0", a_count, a_empty, a_valid, a_dout, a_push_ok); end
      tick(); tick();
      a_rst = 1'b1;
      a_din = 32'h33;
      tick();
      a_push = 1'b0;
      #1;
      total++; if (a_dout !== 32'h33 || a_count !== 4'd1) begin bad++; $display("FAIL post_rst got d=%h c=%0d exp d=33 c=1", a_dout, a_count); end
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      #1;
   endtask

   task automatic test_bypass();
      a_push = 1'b1; a_din = 32'h5A; a_pop = 1'b1;
      #1;
      if (BYP) begin
         total++; if (a_valid !== 1'b1 || a_dout !== 32'h5A) begin bad++; $display("FAIL byp_same got v=%b d=%h exp v=1 d=5a", a_valid, a_dout); end
      end else begin
         total++; if (a_valid !== 1'b0 || a_dout !== '0) begin bad++; $display("FAIL nobyp_same got v=%b d=%h exp v=0 d=0", a_valid, a_dout); end
      end
      tick();
      a_push = 1'b0; a_pop = 1'b0;
      #1;
      if (BYP) begin
         total++; if (a_empty !== 1'b1 || a_count !== 4'd0) begin bad++; $display("FAIL byp_next got e=%b c=%0d exp e=1 c=0", a_empty, a_count); end
      end else begin
         total++; if (a_count !== 4'd1 || a_dout !== 32'h5A) begin bad++; $display("FAIL nobyp_next got c=%0d d=%h exp c=1 d=5a", a_count, a_dout); end
         a_pop = 1'b1;
         tick();
         a_pop = 1'b0;
         #1;
      end
   endtask

   // Reference model: a plain queue plus the acceptance rules.
   task automatic test_random();
      int p_push;
      bit pop_ok, push_ok_e, byp, v_e;
      logic [W-1:0] d_e;
      int sz;
      exp_q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         p_push = ((cyc / 40) % 2 == 0) ? 80 : 30;
         a_push  = ($urandom_range(0, 99) < p_push);
         a_pop   = ($urandom_range(0, 99) < 100 - p_push + 10);
         a_flush = ($urandom_range(0, 99) < 3);
         a_din   = $urandom;
         #1;
         sz  = exp_q.size();
         byp = BYP && sz == 0 && a_push && !a_flush;
         v_e = (sz > 0) || byp;
         d_e = byp ? a_din : (sz > 0 ? exp_q[0] : '0);
         pop_ok    = a_pop && !a_flush && v_e;
         push_ok_e = a_push && !a_flush && (sz < 8 || pop_ok);
         total++;
         if (a_valid !== v_e || a_dout !== d_e || a_push_ok !== push_ok_e || a_count !== 4'(sz) ||
             a_empty !== (sz == 0) || a_full !== (sz == 8) || a_af !== (8 - sz <= 2)) begin
            bad++;
            $display("FAIL rand cyc=%0d got v=%b d=%h ok=%b c=%0d e=%b f=%b af=%b exp v=%b d=%h ok=%b c=%0d",
                     cyc, a_valid, a_dout, a_push_ok, a_count, a_empty, a_full, a_af, v_e, d_e, push_ok_e, sz);
         end
         if (a_flush) exp_q.delete();
         else begin
            if (byp && pop_ok) ;
            else begin
               if (pop_ok) void'(exp_q.pop_front());
               if (push_ok_e) exp_q.push_back(a_din);
            end
         end
         tick();
      end
      a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_fill();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_flush();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
